// File: rtl/std_arb_pkg.sv
// ---------------------------------------------------------------------------
// std_arb_pkg
//   Shared types and helpers for the std_* round-robin arbiters.
//   - arb_state_t : access FSM states (IDLE, ACCESS, WAIT_W, RESP)
//   - rr_pick_t   : result of a round-robin search (found flag + index)
//   - rr_next()   : round-robin search starting just after ptr
// ---------------------------------------------------------------------------
package std_arb_pkg;

  // Largest requester count the helper supports; requester vectors are
  // zero-extended to this width before the search.
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT_W = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Rotate the request vector so position ptr+1 comes first, take the first
  // set bit, and map that rotated position back to a requester index. The
  // wrap is a single conditional subtract because ptr+1+k < 2*num_req.
  function automatic rr_pick_t rr_next(input logic [2:0]         ptr,
                                       input logic [MAX_REQ-1:0] reqs,
                                       input int                 num_req);
    rr_pick_t   r;
    logic [3:0] j;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = {1'b0, ptr} + 4'd1 + 4'(k);
      if (j >= 4'(num_req)) j = j - 4'(num_req);
      if ((k < num_req) && !r.found && reqs[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/std_mem_d1_arbiter_if.sv
// ---------------------------------------------------------------------------
// std_mem_d1_arbiter_if
//   Bundles the requester-side go/done signals and the memory-side std_mem_d1
//   signals seen by std_mem_d1_arbiter.
//   Requester side : req_go, req_write_en, req_addr, req_write_data (flattened,
//                    slice i per requester), req_done, read_data, grant
//   Memory side    : mem_addr0, mem_write_data, mem_write_en, mem_read_data,
//                    mem_done
//   modport slave  : the arbiter
//   modport master : the environment (requesters + memory)
// ---------------------------------------------------------------------------
interface std_mem_d1_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic [NUM_REQ-1:0]          req_go;
  logic [NUM_REQ-1:0]          req_write_en;
  logic [NUM_REQ*IDX_SIZE-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]    req_write_data;
  logic [NUM_REQ-1:0]          req_done;
  logic [WIDTH-1:0]            read_data;
  logic [NUM_REQ-1:0]          grant;
  logic [IDX_SIZE-1:0]         mem_addr0;
  logic [WIDTH-1:0]            mem_write_data;
  logic                        mem_write_en;
  logic [WIDTH-1:0]            mem_read_data;
  logic                        mem_done;

  modport slave (
    input  req_go, req_write_en, req_addr, req_write_data, mem_read_data, mem_done,
    output req_done, read_data, grant, mem_addr0, mem_write_data, mem_write_en
  );

  modport master (
    output req_go, req_write_en, req_addr, req_write_data, mem_read_data, mem_done,
    input  req_done, read_data, grant, mem_addr0, mem_write_data, mem_write_en
  );
endinterface

// File: rtl/std_rr_pick.sv
// ---------------------------------------------------------------------------
// std_rr_pick
//   Combinational round-robin picker: the first active request after ptr
//   (wrapping modulo NUM_REQ) wins.
//   req      in  NUM_REQ   active requests
//   ptr      in  REQ_IDX   index served last (lowest priority this round)
//   grant_oh out NUM_REQ   one-hot winner, zero when nothing is requested
//   idx      out REQ_IDX   winner index
//   valid    out 1         at least one request is active
// ---------------------------------------------------------------------------
module std_rr_pick
  import std_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_IDX = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_IDX-1:0] ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [REQ_IDX-1:0] idx,
  output logic               valid
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;
  rr_pick_t           pick;

  assign req_ext = MAX_REQ'(req);
  assign ptr_ext = 3'(ptr);

  // NOTE: every output gets a value before any branch, so no latch is inferred.
  always_comb begin
    pick  = rr_next(ptr_ext, req_ext, NUM_REQ);
    valid = pick.found;
    idx   = REQ_IDX'(pick.idx);
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = pick.found && (pick.idx == 3'(i));
    end
  end

endmodule

// File: rtl/std_mem_d1_arbiter.sv
// ---------------------------------------------------------------------------
// std_mem_d1_arbiter
//   Round-robin arbiter sharing one std_mem_d1 among NUM_REQ go/done
//   requesters; one read or write per go.
//   clk    in  1   clock, all state updates on posedge
//   reset  in  1   synchronous, active-high
//   bus    slave   requester go/done side and memory side (see interface)
//   Timing from a go sampled in IDLE at cycle t: read done at t+2; write
//   strobes mem_write_en at t+1 and is done at t+3 (memory done one cycle
//   after write_en).
// ---------------------------------------------------------------------------
module std_mem_d1_arbiter
  import std_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int REQ_IDX  = 2,
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input logic                 clk,
  input logic                 reset,
  std_mem_d1_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (NUM_REQ > (2 ** REQ_IDX)) begin : g_bad_req_idx
    $error("REQ_IDX too narrow for NUM_REQ");
  end
  if (SIZE > (2 ** IDX_SIZE)) begin : g_bad_size
    $error("IDX_SIZE too narrow for SIZE");
  end

  arb_state_t          state_q, state_d;
  logic [REQ_IDX-1:0]  ptr_q;
  logic [NUM_REQ-1:0]  sel_q;
  logic                we_q;
  logic [IDX_SIZE-1:0] addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [WIDTH-1:0]    rdata_q;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [REQ_IDX-1:0]  pick_idx;
  logic                pick_valid;

  std_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .REQ_IDX(REQ_IDX)
  ) u_pick (
    .req     (bus.req_go),
    .ptr     (ptr_q),
    .grant_oh(pick_oh),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. RESP always returns to IDLE, so no grant is made in
  // the cycle a done is presented.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = we_q ? WAIT_W : RESP;
      WAIT_W:  if (bus.mem_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so reset clears them at once.
  always_comb begin
    bus.mem_write_en = (state_q == ACCESS) && we_q;
    bus.grant        = (state_q != IDLE) ? sel_q : '0;
    bus.req_done     = (state_q == RESP) ? sel_q : '0;
  end

  assign bus.mem_addr0      = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.read_data      = rdata_q;

  // Grant-time capture and read capture. addr/write_data hold between
  // accesses; read_data is only touched by reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= REQ_IDX'(NUM_REQ - 1);
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && pick_valid) begin
        ptr_q   <= pick_idx;
        sel_q   <= pick_oh;
        we_q    <= bus.req_write_en[pick_idx];
        addr_q  <= bus.req_addr[pick_idx*IDX_SIZE +: IDX_SIZE];
        wdata_q <= bus.req_write_data[pick_idx*WIDTH +: WIDTH];
      end
      if (state_q == ACCESS && !we_q) rdata_q <= bus.mem_read_data;
    end
  end

endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_std_mem_d1_arbiter
//   Directed stimulus for std_mem_d1_arbiter against a small std_mem_d1-like
//   memory. Expected done events are queued at issue time and matched by an
//   independent monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_std_mem_d1_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int REQ_IDX  = 2;
  localparam int WIDTH    = 32;
  localparam int SIZE     = 16;
  localparam int IDX_SIZE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  std_mem_d1_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus ();

  std_mem_d1_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_IDX(REQ_IDX), .WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- memory model ----------------
  logic [WIDTH-1:0] mem [SIZE];
  logic             mem_init;

  function automatic logic [WIDTH-1:0] init_val(input int i);
    return (i == 3) ? 32'h0000_00A5 : 32'hC0DE_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= init_val(i);
    end else if (bus.mem_write_en) begin
      mem[bus.mem_addr0] <= bus.mem_write_data;
    end
    bus.mem_done <= reset ? 1'b0 : bus.mem_write_en;
  end
  assign bus.mem_read_data = mem[bus.mem_addr0];

  // ---------------- bookkeeping ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int               req;
    int               cyc;
    logic             is_read;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   done_seen = 0;

  // Monitor: every done must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.req_done !== '0) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.req_done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_onehot", 64'($countones(bus.req_done)), 64'd1);
        check("done_vec", 64'(bus.req_done), 64'(1 << mon_e.req));
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("grant_at_done", 64'(bus.grant), 64'(1 << mon_e.req));
        if (mon_e.is_read) check("read_data", 64'(bus.read_data), 64'(mon_e.data));
      end
    end
  end

  // Write strobe watcher.
  int                  we_count = 0;
  int                  we_cyc   = -1;
  logic [IDX_SIZE-1:0] we_addr;
  logic [WIDTH-1:0]    we_data;
  always @(negedge clk) begin
    if (bus.mem_write_en === 1'b1) begin
      we_count++;
      we_cyc  = cyc;
      we_addr = bus.mem_addr0;
      we_data = bus.mem_write_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  int remaining [NUM_REQ];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic go, input logic we,
                         input logic [IDX_SIZE-1:0] a, input logic [WIDTH-1:0] d);
    bus.req_go[i]                         = go;
    bus.req_write_en[i]                   = we;
    bus.req_addr[i*IDX_SIZE +: IDX_SIZE]  = a;
    bus.req_write_data[i*WIDTH +: WIDTH]  = d;
  endtask

  // Wait for n dones (bounded); drop each go once its remaining count hits 0.
  task automatic service(input int n, input int budget);
    int got = 0;
    int k   = 0;
    while (got < n && k < budget) begin
      @(negedge clk);
      k++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_done[i] === 1'b1) begin
          got++;
          if (remaining[i] > 0) begin
            remaining[i]--;
            if (remaining[i] == 0) bus.req_go[i] = 1'b0;
          end
        end
      end
    end
    check("service_count", 64'(got), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int t;
    int c;
    int we_base;
    reset              = 1'b1;
    mem_init           = 1'b1;
    bus.req_go         = '0;
    bus.req_write_en   = '0;
    bus.req_addr       = '0;
    bus.req_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;

    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_done", 64'(bus.req_done), 64'd0);
    check("rst_we", 64'(bus.mem_write_en), 64'd0);
    check("rst_read_data", 64'(bus.read_data), 64'd0);
    check("rst_addr", 64'(bus.mem_addr0), 64'd0);
    check("rst_wdata", 64'(bus.mem_write_data), 64'd0);

    // 1: read of addr 3 by requester 0
    tick();
    t = cyc;
    set_req(0, 1'b1, 1'b0, 4'd3, '0);
    remaining[0] = 1;
    sb.push_back('{req: 0, cyc: t + 2, is_read: 1'b1, data: 32'h0000_00A5});
    service(1, 20);
    check("t1_no_write", 64'(we_count), 64'd0);

    // 2: write 0x1234 to addr 5 by requester 1, then read it back
    tick();
    t = cyc;
    set_req(1, 1'b1, 1'b1, 4'd5, 32'h1234);
    remaining[1] = 1;
    sb.push_back('{req: 1, cyc: t + 3, is_read: 1'b0, data: '0});
    service(1, 20);
    check("t2_we_count", 64'(we_count), 64'd1);
    check("t2_we_cycle", 64'(we_cyc), 64'(t + 1));
    check("t2_we_addr", 64'(we_addr), 64'd5);
    check("t2_we_data", 64'(we_data), 64'h1234);
    tick();
    t = cyc;
    set_req(1, 1'b1, 1'b0, 4'd5, '0);
    remaining[1] = 1;
    sb.push_back('{req: 1, cyc: t + 2, is_read: 1'b1, data: 32'h1234});
    service(1, 20);
    check("t2_read_no_write", 64'(we_count), 64'd1);

    // 3: after reset, all four requesters at once -> 0,1,2,3
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    t = cyc;
    set_req(0, 1'b1, 1'b0, 4'd4, '0);
    set_req(1, 1'b1, 1'b0, 4'd8, '0);
    set_req(2, 1'b1, 1'b0, 4'd12, '0);
    set_req(3, 1'b1, 1'b0, 4'd3, '0);
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 1;
    sb.push_back('{req: 0, cyc: t + 2,  is_read: 1'b1, data: 32'hC0DE_0004});
    sb.push_back('{req: 1, cyc: t + 5,  is_read: 1'b1, data: 32'hC0DE_0008});
    sb.push_back('{req: 2, cyc: t + 8,  is_read: 1'b1, data: 32'hC0DE_000C});
    sb.push_back('{req: 3, cyc: t + 11, is_read: 1'b1, data: 32'h0000_00A5});
    service(4, 40);

    // 4: requesters 0 and 2 held for 8 reads -> 0,2,0,2,...
    tick();
    t = cyc;
    set_req(0, 1'b1, 1'b0, 4'd7, '0);
    set_req(2, 1'b1, 1'b0, 4'd9, '0);
    remaining[0] = 4;
    remaining[2] = 4;
    for (int k = 0; k < 8; k++) begin
      sb.push_back('{req: (k % 2 == 0) ? 0 : 2, cyc: t + 2 + 3 * k, is_read: 1'b1,
                     data: (k % 2 == 0) ? 32'hC0DE_0007 : 32'hC0DE_0009});
    end
    service(8, 60);

    // 5: reset while a write sits in WAIT_W
    tick();
    we_base = we_count;
    set_req(1, 1'b1, 1'b1, 4'd6, 32'hDEAD_BEEF);
    tick();              // ACCESS
    tick();              // WAIT_W
    reset = 1'b1;
    tick();              // back in IDLE
    reset = 1'b0;
    c = cyc;
    set_req(0, 1'b1, 1'b0, 4'd6, '0);
    set_req(1, 1'b1, 1'b0, 4'd2, '0);
    @(negedge clk);
    check("t5_grant", 64'(bus.grant), 64'd0);
    check("t5_done", 64'(bus.req_done), 64'd0);
    check("t5_we", 64'(bus.mem_write_en), 64'd0);
    check("t5_write_kept", 64'(mem[6]), 64'hDEAD_BEEF);
    check("t5_we_count", 64'(we_count), 64'(we_base + 1));
    remaining[0] = 1;
    remaining[1] = 1;
    sb.push_back('{req: 0, cyc: c + 2, is_read: 1'b1, data: 32'hDEAD_BEEF});
    sb.push_back('{req: 1, cyc: c + 5, is_read: 1'b1, data: 32'hC0DE_0002});
    service(2, 30);

    // 6: requester 3 reads addr 15 and drops go one cycle in
    tick();
    t = cyc;
    set_req(3, 1'b1, 1'b0, 4'd15, '0);
    remaining[3] = 0;
    sb.push_back('{req: 3, cyc: t + 2, is_read: 1'b1, data: 32'hC0DE_000F});
    tick();
    bus.req_go[3] = 1'b0;
    service(1, 20);

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("done_total", 64'(done_seen), 64'd18);
    check("mem5_final", 64'(mem[5]), 64'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
